// File: rtl/alu_arith_unit.sv
// ---------------------------------------------------------------------------
// alu_arith_unit
//
// Registered integer arithmetic / set-on-compare unit for the execute stage.
// One shared adder serves ADD (in1 + in2) and, with B inverted and a carry-in
// of one, SUB and all compares (in1 - in2). Results land in flops one cycle
// after an accepted in_valid; with in_valid low the result flops hold.
//
// Parameters:
//   WIDTH      operand / result width in bits (>= 2)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands and selects valid this cycle
//   in1, in2   two's-complement operands A and B
//   sel0..sel4 operation select (sel4=0 ADD; sel4=1,sel3=1 SUB;
//              sel4=1,sel3=0 compare decoded on {sel2,sel1,sel0})
//   out        registered result (compares are zero-extended flags)
//   cout       registered carry-out (SUB: 1 = no borrow)
//   overflow   registered signed overflow
//   out_valid  registered, high the cycle after an accepted in_valid
//
// Optional build macro ALU_ARITH_DEBUG_EN adds unregistered probe outputs:
//   sum        in1 + in2
//   diff       in1 - in2
//   in2_final  adder B operand (in2 for ADD, ~in2 otherwise)
// ---------------------------------------------------------------------------
module alu_arith_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
    input  logic             sel4,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
`ifdef ALU_ARITH_DEBUG_EN
    ,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] diff,
    output logic [WIDTH-1:0] in2_final
`endif
);

    localparam int unsigned MSB = WIDTH - 1;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_SEQ,
        OP_SNE,
        OP_SLT,
        OP_SGT,
        OP_SLE,
        OP_SGE,
        OP_RSVD
    } op_e;

    op_e op;

    // Priority decode: sel4 first, then sel3, then the compare code.
    always_comb begin
        op = OP_ADD;
        if (sel4) begin
            if (sel3) begin
                op = OP_SUB;
            end else begin
                unique case ({sel2, sel1, sel0})
                    3'b000:  op = OP_SEQ;
                    3'b001:  op = OP_SNE;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SGT;
                    3'b100:  op = OP_SLE;
                    3'b110:  op = OP_SGE;
                    default: op = OP_RSVD;
                endcase
            end
        end
    end

    // Shared adder: A + B for ADD, A + ~B + 1 for everything else.
    logic             is_add;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_res;
    logic             add_c;
    logic             add_v;

    assign is_add   = (op == OP_ADD);
    assign b_op     = is_add ? in2 : ~in2;
    assign add_full = {1'b0, in1} + {1'b0, b_op} + {{WIDTH{1'b0}}, ~is_add};
    assign add_res  = add_full[WIDTH-1:0];
    assign add_c    = add_full[WIDTH];

    // Using the inverted B operand makes one rule cover both ADD and SUB:
    // overflow when A and B' agree in sign and the result does not.
    assign add_v = (in1[MSB] == b_op[MSB]) && (add_res[MSB] != in1[MSB]);

    // Signed compare flags from the subtractor; sign XOR overflow gives the
    // true sign of in1 - in2 even when the subtraction wraps.
    logic f_eq;
    logic f_lt;
    logic f_gt;
    logic f_le;
    logic f_ge;

    assign f_eq = (in1 == in2);
    assign f_lt = add_res[MSB] ^ add_v;
    assign f_gt = ~f_lt & ~f_eq;
    assign f_le = f_lt | f_eq;
    assign f_ge = ~f_lt;

    // Result selection.
    logic [WIDTH-1:0] out_d;
    logic             cout_d;
    logic             ovf_d;
    logic             flag;

    always_comb begin
        out_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        flag   = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                out_d  = add_res;
                cout_d = add_c;
                ovf_d  = add_v;
            end
            OP_SEQ:  flag = f_eq;
            OP_SNE:  flag = ~f_eq;
            OP_SLT:  flag = f_lt;
            OP_SGT:  flag = f_gt;
            OP_SLE:  flag = f_le;
            OP_SGE:  flag = f_ge;
            default: flag = 1'b0;
        endcase
        if (op != OP_ADD && op != OP_SUB) begin
            out_d[0] = flag;
        end
    end

    // Output registers.
    logic [WIDTH-1:0] out_q;
    logic             cout_q;
    logic             ovf_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q  <= out_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out       = out_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign out_valid = valid_q;

`ifdef ALU_ARITH_DEBUG_EN
    assign sum       = in1 + in2;
    assign diff      = in1 - in2;
    assign in2_final = b_op;
`endif

endmodule

// File: tb/tb_alu_arith_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_arith_unit
//
// Directed bench for alu_arith_unit. A behavioural model computes every
// expected output from plain signed/unsigned 64-bit arithmetic; each clock
// cycle the outputs are checked against it, and hand-computed literals pin
// the model on the interesting corner cases.
// ---------------------------------------------------------------------------
module tb_alu_arith_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         sel0, sel1, sel2, sel3, sel4;
    logic [W-1:0] out;
    logic         cout;
    logic         overflow;
    logic         out_valid;
`ifdef ALU_ARITH_DEBUG_EN
    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] in2_final;
`endif

    alu_arith_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .sel0      (sel0),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel4      (sel4),
        .out       (out),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
`ifdef ALU_ARITH_DEBUG_EN
        ,
        .sum       (sum),
        .diff      (diff),
        .in2_final (in2_final)
`endif
    );

    always #5 clk = ~clk;

    typedef enum int {T_ADD, T_SUB, T_SEQ, T_SNE, T_SLT, T_SGT, T_SLE, T_SGE,
                      T_RSV5, T_RSV7} op_t;

    int total = 0;
    int bad   = 0;

    bit           m_known = 1'b0;
    logic [W-1:0] m_out;
    logic         m_cout;
    logic         m_ovf;
    logic         m_valid;

    task automatic set_op(input op_t op);
        logic [31:0] rnd;
        rnd = $urandom;
        {sel4, sel3, sel2, sel1, sel0} = {1'b1, 1'b0, 3'b000};
        case (op)
            T_ADD:  {sel4, sel3, sel2, sel1, sel0} = {1'b0, rnd[3:0]};
            T_SUB:  {sel4, sel3, sel2, sel1, sel0} = {2'b11, rnd[2:0]};
            T_SEQ:  {sel2, sel1, sel0} = 3'b000;
            T_SNE:  {sel2, sel1, sel0} = 3'b001;
            T_SLT:  {sel2, sel1, sel0} = 3'b010;
            T_SGT:  {sel2, sel1, sel0} = 3'b011;
            T_SLE:  {sel2, sel1, sel0} = 3'b100;
            T_SGE:  {sel2, sel1, sel0} = 3'b110;
            T_RSV5: {sel2, sel1, sel0} = 3'b101;
            default: {sel2, sel1, sel0} = 3'b111;
        endcase
    endtask

    // Reference arithmetic from the operation rules, in 64-bit integers.
    task automatic model_calc(output logic [W-1:0] r, output logic c,
                              output logic v);
        longint ua, ub, sa, sb, u, s, maxs, mins;
        bit     flag;
        ua   = longint'(in1);
        ub   = longint'(in2);
        sa   = longint'($signed(in1));
        sb   = longint'($signed(in2));
        maxs = (longint'(1) << (W - 1)) - 1;
        mins = -(longint'(1) << (W - 1));
        r = '0;
        c = 1'b0;
        v = 1'b0;
        if (!sel4) begin
            u = ua + ub;
            s = sa + sb;
            r = u[W-1:0];
            c = u[W];
            v = (s > maxs) || (s < mins);
        end else if (sel3) begin
            u = ua - ub;
            s = sa - sb;
            r = u[W-1:0];
            c = (ua >= ub);
            v = (s > maxs) || (s < mins);
        end else begin
            flag = 1'b0;
            case ({sel2, sel1, sel0})
                3'b000:  flag = (sa == sb);
                3'b001:  flag = (sa != sb);
                3'b010:  flag = (sa <  sb);
                3'b011:  flag = (sa >  sb);
                3'b100:  flag = (sa <= sb);
                3'b110:  flag = (sa >= sb);
                default: flag = 1'b0;
            endcase
            r[0] = flag;
        end
    endtask

    // Advance the model over one edge, then compare every output to it.
    task automatic cycle();
        logic [W-1:0] r;
        logic         c, v;
        if (rst) begin
            m_out   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_known = 1'b1;
        end else if (in_valid) begin
            model_calc(r, c, v);
            m_out   = r;
            m_cout  = c;
            m_ovf   = v;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (m_known) begin
            total++;
            if (out !== m_out || cout !== m_cout || overflow !== m_ovf ||
                out_valid !== m_valid) begin
                bad++;
                $display("FAIL model t=%0t: got out=%h cout=%b ovf=%b valid=%b, want out=%h cout=%b ovf=%b valid=%b",
                         $time, out, cout, overflow, out_valid,
                         m_out, m_cout, m_ovf, m_valid);
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [W-1:0] eo,
                             input logic ec, input logic ev, input logic evld);
        total++;
        if (out !== eo || cout !== ec || overflow !== ev || out_valid !== evld) begin
            bad++;
            $display("FAIL %s: got out=%h cout=%b ovf=%b valid=%b, want out=%h cout=%b ovf=%b valid=%b",
                     name, out, cout, overflow, out_valid, eo, ec, ev, evld);
        end
    endtask

    task automatic run(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        set_op(op);
        cycle();
    endtask

    logic [W-1:0] corner [6];

    initial begin
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        corner[5] = 32'h1234_5678;

        // Reset held two cycles with valid traffic presented.
        rst      = 1'b1;
        in_valid = 1'b1;
        in1      = $urandom;
        in2      = $urandom;
        set_op(T_ADD);
        @(negedge clk);
        cycle();
        in1 = $urandom;
        in2 = $urandom;
        cycle();
        check_lit("reset", '0, 1'b0, 1'b0, 1'b0);

        rst = 1'b0;
        run(T_ADD, 32'd5, 32'd7);
        check_lit("first_result", 32'd12, 1'b0, 1'b0, 1'b1);

        // in1 = in2 = 1 swept through every operation back-to-back.
        run(T_SEQ, 1, 1); check_lit("seq_1_1", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_SNE, 1, 1); check_lit("sne_1_1", 32'd0, 1'b0, 1'b0, 1'b1);
        run(T_SLT, 1, 1); check_lit("slt_1_1", 32'd0, 1'b0, 1'b0, 1'b1);
        run(T_SGT, 1, 1); check_lit("sgt_1_1", 32'd0, 1'b0, 1'b0, 1'b1);
        run(T_SLE, 1, 1); check_lit("sle_1_1", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_SGE, 1, 1); check_lit("sge_1_1", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_SUB, 1, 1); check_lit("sub_1_1", 32'd0, 1'b1, 1'b0, 1'b1);
        run(T_ADD, 1, 1); check_lit("add_1_1", 32'd2, 1'b0, 1'b0, 1'b1);

        // Arithmetic boundaries.
        run(T_ADD, 32'h7FFF_FFFF, 32'h1);
        check_lit("add_pos_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        run(T_ADD, 32'hFFFF_FFFF, 32'h1);
        check_lit("add_carry", 32'h0, 1'b1, 1'b0, 1'b1);
        run(T_SUB, 32'h8000_0000, 32'h1);
        check_lit("sub_neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1);
        run(T_SUB, 32'h0, 32'h1);
        check_lit("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

        // Signed compares, including an overflowing subtraction.
        run(T_SLT, 32'hFFFF_FFFF, 32'h1);
        check_lit("slt_neg", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_SGT, 32'h8000_0000, 32'h7FFF_FFFF);
        check_lit("sgt_ovf", 32'd0, 1'b0, 1'b0, 1'b1);
        run(T_SGE, 32'h7FFF_FFFF, 32'h8000_0000);
        check_lit("sge_ovf", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_SEQ, 32'd5, 32'd5);
        check_lit("seq_5", 32'd1, 1'b0, 1'b0, 1'b1);
        run(T_RSV5, 32'd5, 32'd5);
        check_lit("rsv_101", 32'd0, 1'b0, 1'b0, 1'b1);
        run(T_SEQ, 32'd5, 32'd5);
        run(T_RSV7, 32'd5, 32'd5);
        check_lit("rsv_111", 32'd0, 1'b0, 1'b0, 1'b1);

        // Hold with in_valid low while operands keep changing.
        run(T_ADD, 32'hFFFF_FFFF, 32'h2);
        check_lit("pre_hold", 32'd1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b0;
            in1      = $urandom;
            in2      = $urandom;
            set_op(T_SUB);
            cycle();
            check_lit("hold", 32'd1, 1'b1, 1'b0, 1'b0);
        end

        // Reset arriving alongside a valid ADD discards it.
        run(T_ADD, 32'd10, 32'd20);
        check_lit("pre_rst", 32'd30, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        run(T_ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        check_lit("mid_rst", 32'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run(T_SUB, 32'd3, 32'd9);
        check_lit("after_rst", 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1);

        // Mixed traffic on corner and random operands, model-checked.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] rnd;
            rnd      = $urandom;
            in_valid = (rnd[3:0] != 4'd0);
            in1      = rnd[4] ? corner[rnd[7:5] % 6] : $urandom;
            in2      = rnd[8] ? corner[rnd[11:9] % 6] : $urandom;
            set_op(op_t'(rnd[31:16] % 10));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arith_unit.md
Name: alu_arith_unit

Overview:
- Registered 32-bit integer arithmetic/compare unit for the datapath execute stage.
- Performs ADD, SUB and six set-on-compare operations (SEQ, SNE, SLT, SGT, SLE, SGE).
- Operation is chosen by five discrete select bits, sel0..sel4.
- Result, carry and overflow are registered with 1-cycle latency and a valid strobe.

Parameters:
- WIDTH, 32, operand/result width in bits. All behaviour below is stated for 32; any WIDTH >= 2 must work identically.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- in_valid  input  1  operands and selects are valid this cycle.
- in1  input  WIDTH  operand A, two's complement.
- in2  input  WIDTH  operand B, two's complement.
- sel0  input  1  select bit 0.
- sel1  input  1  select bit 1.
- sel2  input  1  select bit 2.
- sel3  input  1  select bit 3 (SUB).
- sel4  input  1  select bit 4 (compare/sub group).
- out  output  WIDTH  registered result.
- cout  output  1  registered carry-out.
- overflow  output  1  registered signed overflow.
- out_valid  output  1  registered; high the cycle after an accepted in_valid.

Behaviour:
- Operation decode, evaluated in priority order:
  - sel4=0: ADD, out = in1 + in2. sel0..sel3 are ignored.
  - sel4=1, sel3=1: SUB, out = in1 - in2. sel0..sel2 are ignored.
  - sel4=1, sel3=0: compare, decoded on {sel2,sel1,sel0}:
    - 000 SEQ (in1 == in2)
    - 001 SNE (in1 != in2)
    - 010 SLT (in1 < in2)
    - 011 SGT (in1 > in2)
    - 100 SLE (in1 <= in2)
    - 110 SGE (in1 >= in2)
    - 101 and 111 are reserved: out = 0, cout = 0, overflow = 0.
- Compares:
  - All compares are signed two's complement.
  - Result is zero-extended: out = {31'b0, flag}.
  - cout = 0 and overflow = 0 for every compare.
  - SLT, SGT, SLE and SGE must be correct even when the subtraction overflows. Derive them from the subtractor's sign XOR overflow, or compare directly.
- ADD:
  - cout = carry out of bit 31.
  - overflow = 1 when the operand signs are equal and the result sign differs from them.
- SUB:
  - Implemented as in1 + ~in2 + 1.
  - cout = carry out of that sum, so 1 means no borrow.
  - overflow = 1 when the operand signs differ and the result sign differs from in1's sign.
- Wrap-around: ADD and SUB results are modulo 2^32; no saturation.
- Timing:
  - On a rising edge with rst=0 and in_valid=1: out, cout and overflow load the computed values, and out_valid <= 1.
  - On a rising edge with rst=0 and in_valid=0: out, cout and overflow hold their previous values, and out_valid <= 0.
  - Latency is exactly 1 cycle; a new operation can be accepted every cycle.
- Reset: on a rising edge with rst=1, out = 0, cout = 0, overflow = 0 and out_valid = 0, regardless of in_valid. Asserting reset mid-stream discards the operation presented in that cycle.
- No combinational path from any input to any output; all outputs come straight from flops.

Optional Feature:
- Macro ALU_ARITH_DEBUG_EN.
- When defined, the following extra combinational output ports are present (unregistered, for bench probing):
  - sum (WIDTH) = in1 + in2.
  - diff (WIDTH) = in1 - in2.
  - in2_final (WIDTH) = the adder B operand: in2 for ADD, ~in2 otherwise.
- When undefined, these ports and their logic are absent. Registered behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and random operands -> out=0, cout=0, overflow=0, out_valid=0. Release rst -> the first result appears exactly 1 cycle after the first accepted in_valid.
- in1=1, in2=1, stepped back-to-back through SEQ, SNE, SLT, SGT, SLE, SGE, SUB, ADD -> out = 1, 0, 0, 0, 1, 1, 0, 2 on successive cycles, each 1 cycle late. SUB gives cout=1. ADD gives cout=0 and overflow=0.
- ADD, in1=0x7FFFFFFF, in2=0x00000001 -> out=0x80000000, overflow=1, cout=0. ADD, in1=0xFFFFFFFF, in2=0x00000001 -> out=0, cout=1, overflow=0.
- SUB, in1=0x80000000, in2=0x00000001 -> out=0x7FFFFFFF, overflow=1, cout=1. SUB, in1=0, in2=1 -> out=0xFFFFFFFF, cout=0.
- Signed compares:
  - SLT, in1=0xFFFFFFFF, in2=1 -> out=1.
  - SGT, in1=0x80000000, in2=0x7FFFFFFF -> out=0 (this case overflows the subtractor).
  - Reserved code {sel2,sel1,sel0}=101 -> out=0.
- Hold behaviour: in_valid=0 for 3 cycles with changing operands -> out, cout and overflow unchanged, out_valid=0. Assert rst during a valid ADD -> outputs are 0 on the next cycle.
